// File: rtl/bht_update_queue.sv
// bht_update_queue_pkg / bht_update_queue
//
// Purpose: small circular queue that buffers resolved conditional-branch
// outcomes from the branch unit and replays them to the BHT update port,
// at most one per cycle. When the queue is full and nothing drains, the
// oldest entry is dropped to make room and a saturating drop counter
// records the loss.
//
// Ports:
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   flush_i             discard all queued updates (drop counter kept)
//   debug_mode_i        ignore new pushes; queued entries still drain
//   resolved_valid_i    branch unit resolved an instruction this cycle
//   resolved_pc_i       PC of the resolved instruction
//   resolved_taken_i    actual outcome
//   resolved_is_cond_i  instruction is a conditional branch
//   hold_i              BHT update port busy; do not pop
//   bht_update_o        {valid, pc, taken} toward the BHT (combinational)
//   occupancy_o         number of queued entries (registered)
//   drop_cnt_o          saturating count of updates lost to overflow

package bht_update_queue_pkg;
    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;
endpackage

module bht_update_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned VLEN       = bht_update_queue_pkg::VLEN,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              debug_mode_i,
    input  logic                              resolved_valid_i,
    input  logic [VLEN-1:0]                   resolved_pc_i,
    input  logic                              resolved_taken_i,
    input  logic                              resolved_is_cond_i,
    input  logic                              hold_i,
    output bht_update_queue_pkg::bht_update_t bht_update_o,
    output logic [$clog2(DEPTH):0]            occupancy_o,
    output logic [DROP_CNT_W-1:0]             drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [VLEN-1:0]       mem_pc    [DEPTH];
    logic                  mem_taken [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DROP_CNT_W-1:0] drop_cnt;

    logic push;
    logic pop;
    logic full;
    logic drop;

    assign push = resolved_valid_i && resolved_is_cond_i && !debug_mode_i && !flush_i;
    assign pop  = (count != '0) && !hold_i && !flush_i;
    assign full = (count == FULL_CNT);
    // Full and not draining: evict the head so the newest outcome is kept.
    assign drop = push && full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc[i]    <= '0;
                mem_taken[i] <= 1'b0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= resolved_pc_i;
                mem_taken[wr_ptr] <= resolved_taken_i;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop || drop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Push+pop and drop both leave the count unchanged.
            if (push && !pop && !full) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop && !(&drop_cnt)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    // pc/taken always reflect the head slot, even when valid is low.
    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = pop;
        bht_update_o.pc    = mem_pc[rd_ptr];
        bht_update_o.taken = mem_taken[rd_ptr];
    end

    assign occupancy_o = count;
    assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
module tb_bht_update_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        dbg = 1'b0;
    logic        r_valid = 1'b0;
    logic [63:0] r_pc = '0;
    logic        r_taken = 1'b0;
    logic        r_cond = 1'b0;
    logic        hold = 1'b0;
    bht_update_queue_pkg::bht_update_t upd;
    logic [2:0]  occ;
    logic [7:0]  drop;

    bht_update_queue #(.DEPTH(DEPTH), .VLEN(64), .DROP_CNT_W(8)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .debug_mode_i       (dbg),
        .resolved_valid_i   (r_valid),
        .resolved_pc_i      (r_pc),
        .resolved_taken_i   (r_taken),
        .resolved_is_cond_i (r_cond),
        .hold_i             (hold),
        .bht_update_o       (upd),
        .occupancy_o        (occ),
        .drop_cnt_o         (drop)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {pc, taken} plus a drop count.
    logic [64:0] mq[$];
    int unsigned m_drop = 0;
    logic [63:0] seen[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle from a negedge: check outputs, clock, update the model.
    task automatic step(input logic v, input logic [63:0] pc, input logic tk,
                        input logic cond, input logic hd, input logic fl, input logic dm);
        logic exp_v;
        r_valid = v; r_pc = pc; r_taken = tk; r_cond = cond;
        hold = hd; flush = fl; dbg = dm;
        #1;
        exp_v = (mq.size() != 0) && !hd && !fl;
        chk("valid", 64'(upd.valid), 64'(exp_v));
        if (mq.size() != 0) begin
            chk("pc", upd.pc, mq[0][64:1]);
            chk("taken", 64'(upd.taken), 64'(mq[0][0]));
        end
        chk("occupancy", 64'(occ), 64'(mq.size()));
        chk("drop_cnt", 64'(drop), 64'(m_drop));
        if (upd.valid) seen.push_back(upd.pc);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && !hd) void'(mq.pop_front());
            if (v && cond && !dm) begin
                if (mq.size() == DEPTH) begin
                    void'(mq.pop_front());
                    if (m_drop < 255) m_drop++;
                end
                mq.push_back({pc, tk});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic hd);
        step(1'b0, 64'h0, 1'b0, 1'b0, hd, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [63:0] pc, input logic tk, input logic hd);
        step(1'b1, pc, tk, 1'b1, hd, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_valid", 64'(upd.valid), 64'd0);
        chk("rst_pc", upd.pc, 64'd0);
        chk("rst_taken", 64'(upd.taken), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single push, one-cycle latency, no bypass
        seen.delete();
        push(64'h8000_0010, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t1_count", 64'(seen.size()), 64'd1);
        if (seen.size() >= 1) chk("t1_pc", seen[0], 64'h8000_0010);

        // 2: fill under hold, then drain in order
        seen.delete();
        for (int i = 0; i < 4; i++) push(64'h100 + 64'(4 * i), i[0], 1'b1);
        chk("t2_occ", 64'(occ), 64'd4);
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("t2_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("t2_order", seen[i], 64'h100 + 64'(4 * i));
        chk("t2_drop", 64'(drop), 64'd0);

        // 3: overflow under hold drops the oldest two
        seen.delete();
        for (int i = 0; i < 6; i++) push(64'h200 + 64'(4 * i), 1'b0, 1'b1);
        chk("t3_occ", 64'(occ), 64'd4);
        chk("t3_drop", 64'(drop), 64'd2);
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("t3_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("t3_order", seen[i], 64'h208 + 64'(4 * i));

        // 4: full queue, push+pop every cycle, pointers wrap
        for (int i = 0; i < 4; i++) push(64'h280 + 64'(4 * i), 1'b1, 1'b1);
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            push(64'h300 + 64'(4 * i), 1'b0, 1'b0);
            chk("t4_occ", 64'(occ), 64'd4);
        end
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("t4_drop", 64'(drop), 64'd2);
        chk("t4_count", 64'(seen.size()), 64'd14);
        for (int i = 0; i < 10 && 4 + i < seen.size(); i++)
            chk("t4_delay", seen[4 + i], 64'h300 + 64'(4 * i));

        // 5: flush with a same-cycle push
        seen.delete();
        for (int i = 0; i < 3; i++) push(64'h400 + 64'(4 * i), 1'b1, 1'b1);
        step(1'b1, 64'h4F0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_occ", 64'(occ), 64'd0);
        chk("t5_valid", 64'(upd.valid), 64'd0);
        chk("t5_drop", 64'(drop), 64'd2);
        push(64'h500, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t5_count", 64'(seen.size()), 64'd1);
        if (seen.size() >= 1) chk("t5_pc", seen[0], 64'h500);

        // 6: debug mode ignores pushes but drains; non-conditional never enqueued
        seen.delete();
        push(64'h600, 1'b0, 1'b1);
        push(64'h604, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h700 + 64'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t6_count", 64'(seen.size()), 64'd2);
        if (seen.size() >= 2) begin
            chk("t6_pc0", seen[0], 64'h600);
            chk("t6_pc1", seen[1], 64'h604);
        end
        chk("t6_occ", 64'(occ), 64'd0);

        // Drop counter saturation
        for (int i = 0; i < 264; i++) push(64'h900 + 64'(4 * i), 1'b0, 1'b1);
        chk("sat_drop", 64'(drop), 64'd255);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), {$urandom, $urandom}, 1'($urandom),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) push(64'hA00 + 64'(4 * i), 1'b1, 1'b1);
        idle(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(upd.valid), 64'd0);
        chk("arst_occ", 64'(occ), 64'd0);
        chk("arst_drop", 64'(drop), 64'd0);
        mq.delete();
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(($urandom_range(0, 9) < 6), {$urandom, $urandom}, 1'($urandom),
                 1'b1, ($urandom_range(0, 9) < 3), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Buffers resolved conditional-branch outcomes from the execute-stage branch unit.
- Replays them to the branch history table's update port, at most one per cycle.
- Decouples branch resolution bursts from table-update bandwidth and supports a hold window while the table update port is busy.
- Sits between the branch unit and the BHT; its output drives the BHT update input directly.

Parameters:
DEPTH, 4, number of queued updates; power of two, at least 2.
VLEN, riscv::VLEN, virtual PC width.
DROP_CNT_W, 8, width of the saturating overflow counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
flush_i  in  1  discard all queued updates
debug_mode_i  in  1  core in debug mode; new pushes are ignored
resolved_valid_i  in  1  branch unit resolved a control-flow instruction this cycle
resolved_pc_i  in  VLEN  PC of the resolved instruction
resolved_taken_i  in  1  actual outcome
resolved_is_cond_i  in  1  instruction is a conditional branch; only these are enqueued
hold_i  in  1  BHT update port unavailable; do not pop
bht_update_o  out  ariane_pkg::bht_update_t  valid, pc, taken toward the BHT
occupancy_o  out  $clog2(DEPTH)+1  number of entries queued
drop_cnt_o  out  DROP_CNT_W  saturating count of updates lost to overflow

Behaviour:
- Reset:
  - Queue empty; read and write pointers at 0.
  - occupancy_o = 0, drop_cnt_o = 0.
  - bht_update_o.valid = 0; bht_update_o.pc and bht_update_o.taken = 0.
- Storage: circular buffer of DEPTH entries {pc, taken}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - A separate count register of $clog2(DEPTH)+1 bits distinguishes full from empty.
- Push condition: resolved_valid_i && resolved_is_cond_i && !debug_mode_i && !flush_i.
  - The entry is written at the write pointer on the clock edge.
- Pop condition: count > 0 && !hold_i && !flush_i.
  - The read pointer advances on the clock edge.
- Output:
  - bht_update_o is combinational from the head entry.
  - valid = (count > 0) && !hold_i && !flush_i.
  - pc and taken are driven from the head entry even while valid = 0.
  - The BHT samples bht_update_o in the same cycle; a pop happens exactly when valid = 1.
- Latency: a push into an empty queue in cycle N appears with valid = 1 in cycle N+1. There is no bypass.
- Ordering: strict FIFO; updates reach the BHT in resolution order.
- Simultaneous push and pop: the count is unchanged and both pointers advance. This also holds when full.
- Full with push and no pop (hold_i = 1 or flush-free stall): drop-oldest policy.
  - Head advances, the new entry is written at the tail, count stays DEPTH.
  - drop_cnt increments, saturating at all-ones.
- Empty with no push: no change; valid = 0.
- flush_i = 1:
  - Next cycle the count is 0 and both pointers are 0.
  - A same-cycle push is discarded and does not count as a drop.
  - drop_cnt_o is preserved.
- debug_mode_i = 1: pushes are ignored, but draining continues, so queued pre-debug updates still retire. The BHT itself gates updates in debug mode.
- Non-conditional resolved instructions (jumps, returns) are never enqueued.
- occupancy_o equals the count register and is registered.
- An asynchronous reset mid-operation returns all state to reset values immediately, independent of the clock.

Test Plan:
1. Reset, then push pc=0x80000010 taken=1 in cycle 1 with hold_i=0 -> cycle 2: bht_update_o={valid=1, pc=0x80000010, taken=1}; cycle 3: valid=0, occupancy_o=0.
2. hold_i=1, push 4 distinct PCs 0x100,0x104,0x108,0x10C, then release hold -> occupancy_o=4; outputs 0x100,0x104,0x108,0x10C on 4 consecutive cycles; drop_cnt_o=0.
3. hold_i=1, push 6 PCs 0x200..0x214 step 4 -> occupancy_o=4, drop_cnt_o=2; after release, output order is 0x208,0x20C,0x210,0x214.
4. Queue full, hold_i=0, push every cycle for 10 cycles -> occupancy_o stays 4, drop_cnt_o unchanged, each pushed PC is emitted exactly 4 cycles later; pointers wrap correctly.
5. 3 entries queued with hold_i=1, assert flush_i together with a push -> next cycle occupancy_o=0, valid=0, drop_cnt_o unchanged; a following push emerges alone.
6. debug_mode_i=1 with 2 entries queued, push 3 more -> only the 2 original entries are emitted, occupancy_o returns to 0. A push with resolved_is_cond_i=0 is never emitted. Assert rst_ni low mid-drain -> valid=0 and occupancy_o=0 asynchronously.
